// File: rtl/pifo_root_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pifo_root_pkg
// Purpose  : Shared field positions, widths, FSM state encoding and helpers
//            for the root-level PIFO dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package pifo_root_pkg;

    // Default root entry layout: {valid, rank[18:0], addr[11:0]}
    localparam int DEF_BUFFER_ADDR_WIDTH        = 12;
    localparam int DEF_PIFO_RANK_WIDTH          = 19;
    localparam int DEF_PIFO_ROOT_WIDTH          = 32;
    localparam int DEF_ROOT_RANK_START_POS      = 12;
    localparam int DEF_ROOT_RANK_END_POS        = 30;
    localparam int DEF_ROOT_PIFO_INFO_VALID_POS = 31;

    // Width of the optional event counters
    localparam int STAT_CNT_WIDTH = 16;

    // Output slot ownership: empty, holding a bypassed arrival, or holding
    // an entry popped from the calendar
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BYP   = 2'd1,
        CAL   = 2'd2
    } disp_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_CNT_WIDTH-1:0] sat_inc(
        input logic [STAT_CNT_WIDTH-1:0] cnt,
        input logic                      en
    );
        if (en && (cnt != {STAT_CNT_WIDTH{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pifo_root_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : pifo_root_dispatcher_if
// Purpose  : Arrival, calendar and output-slot signal bundle of the root
//            dispatcher. The slave modport is the dispatcher side.
// Revision : 1.0 - initial release
// ============================================================================
interface pifo_root_dispatcher_if #(
    parameter int BUFFER_ADDR_WIDTH = 12,
    parameter int PIFO_RANK_WIDTH   = 19,
    parameter int PIFO_ROOT_WIDTH   = 32
);
    logic [PIFO_ROOT_WIDTH-1:0]   s_pifo_info;
    logic                         s_insert_en;
    logic                         s_bypass_en;
    logic [PIFO_ROOT_WIDTH-1:0]   s_calendar_top;
    logic                         m_calendar_pop;
    logic [PIFO_ROOT_WIDTH-1:0]   m_insert_info;
    logic                         m_insert_en;
    logic [BUFFER_ADDR_WIDTH-1:0] m_out_addr;
    logic [PIFO_RANK_WIDTH-1:0]   m_out_rank;
    logic                         m_out_valid;
    logic                         m_out_ready;

    modport slave (
        input  s_pifo_info, s_insert_en, s_bypass_en, s_calendar_top, m_out_ready,
        output m_calendar_pop, m_insert_info, m_insert_en,
               m_out_addr, m_out_rank, m_out_valid
    );

    modport master (
        output s_pifo_info, s_insert_en, s_bypass_en, s_calendar_top, m_out_ready,
        input  m_calendar_pop, m_insert_info, m_insert_en,
               m_out_addr, m_out_rank, m_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/pifo_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : pifo_out_slot
// Purpose  : One-entry valid/ready holding register. A load overrides a
//            drain in the same cycle so the slot can transfer every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pifo_out_slot #(
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Load new contents, or drop valid once the consumer accepts
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/pifo_root_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pifo_root_dispatcher
// Purpose  : Routes each root PIFO arrival either straight into the output
//            slot (bypass) or into the calendar PIFO (insert), and refills
//            the slot from the calendar head when no bypass claims it.
// Options  : DISPATCH_STATS_EN adds saturating bypass/insert/pop counters.
// Revision : 1.0 - initial release
// ============================================================================
module pifo_root_dispatcher
    import pifo_root_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH        = DEF_BUFFER_ADDR_WIDTH,
    parameter int PIFO_RANK_WIDTH          = DEF_PIFO_RANK_WIDTH,
    parameter int PIFO_ROOT_WIDTH          = DEF_PIFO_ROOT_WIDTH,
    parameter int ROOT_RANK_START_POS      = DEF_ROOT_RANK_START_POS,
    parameter int ROOT_RANK_END_POS        = DEF_ROOT_RANK_END_POS,
    parameter int ROOT_PIFO_INFO_VALID_POS = DEF_ROOT_PIFO_INFO_VALID_POS,
    parameter int BYPASS_SYNC              = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    pifo_root_dispatcher_if.slave         disp
`ifdef DISPATCH_STATS_EN
    ,
    output logic [STAT_CNT_WIDTH-1:0]     stat_bypass_cnt,
    output logic [STAT_CNT_WIDTH-1:0]     stat_insert_cnt,
    output logic [STAT_CNT_WIDTH-1:0]     stat_pop_cnt
`endif
);
    // The slot keeps only address and rank; the valid bit is not forwarded
    localparam int SLOT_WIDTH = ROOT_RANK_END_POS + 1;

    disp_state_e                state_q, state_d;
    logic                       d_valid_raw;
    logic [PIFO_ROOT_WIDTH-1:0] d_info;
    logic                       d_valid;
    logic                       slot_free;
    logic                       bypass_take;
    logic                       insert_d;
    logic                       pop_d;
    logic                       slot_load;
    logic [SLOT_WIDTH-1:0]      slot_load_data;
    logic                       slot_valid;
    logic [SLOT_WIDTH-1:0]      slot_data;
    logic [PIFO_RANK_WIDTH-1:0] slot_rank;
    logic                       pop_q;
    logic                       ins_en_q;
    logic [PIFO_ROOT_WIDTH-1:0] ins_info_q;

    // Align the arrival with its bypass verdict
    generate
        if (BYPASS_SYNC != 0) begin : g_sync_stage
            logic                       d_valid_q;
            logic [PIFO_ROOT_WIDTH-1:0] d_info_q;

            // Hold the arrival one cycle until its late verdict shows up
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    d_valid_q <= 1'b0;
                    d_info_q  <= '0;
                end else begin
                    d_valid_q <= disp.s_insert_en;
                    d_info_q  <= disp.s_pifo_info;
                end
            end

            assign d_valid_raw = d_valid_q;
            assign d_info      = d_info_q;
        end else begin : g_direct_stage
            assign d_valid_raw = disp.s_insert_en;
            assign d_info      = disp.s_pifo_info;
        end
    endgenerate

    // Dispatch decision and next-state: bypass > insert, pop only if slot unclaimed
    always_comb begin
        state_d        = state_q;
        slot_free      = (state_q == EMPTY) | (slot_valid & disp.m_out_ready);
        d_valid        = d_valid_raw & d_info[ROOT_PIFO_INFO_VALID_POS];
        bypass_take    = d_valid & disp.s_bypass_en & slot_free;
        insert_d       = d_valid & ~bypass_take;
        // The calendar head is stale in the cycle its pop strobe is high
        pop_d          = ~bypass_take & slot_free
                       & disp.s_calendar_top[ROOT_PIFO_INFO_VALID_POS] & ~pop_q;
        slot_load      = bypass_take | pop_d;
        slot_load_data = bypass_take ? d_info[SLOT_WIDTH-1:0]
                                     : disp.s_calendar_top[SLOT_WIDTH-1:0];
        if (bypass_take) begin
            state_d = BYP;
        end else if (pop_d) begin
            state_d = CAL;
        end else if (slot_valid && disp.m_out_ready) begin
            state_d = EMPTY;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered pop and insert strobes toward the calendar
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pop_q      <= 1'b0;
            ins_en_q   <= 1'b0;
            ins_info_q <= '0;
        end else begin
            pop_q    <= pop_d;
            ins_en_q <= insert_d;
            if (insert_d) begin
                ins_info_q <= d_info;
            end
        end
    end

    pifo_out_slot #(
        .DATA_WIDTH (SLOT_WIDTH)
    ) u_slot (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (slot_load),
        .load_data_i (slot_load_data),
        .ready_i     (disp.m_out_ready),
        .valid_o     (slot_valid),
        .data_o      (slot_data)
    );

    assign slot_rank           = slot_data[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
    assign disp.m_out_addr     = slot_data[BUFFER_ADDR_WIDTH-1:0];
    assign disp.m_out_rank     = slot_rank;
    assign disp.m_out_valid    = slot_valid;
    assign disp.m_calendar_pop = pop_q;
    assign disp.m_insert_en    = ins_en_q;
    assign disp.m_insert_info  = ins_info_q;

`ifdef DISPATCH_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] bypass_cnt_q;
    logic [STAT_CNT_WIDTH-1:0] insert_cnt_q;
    logic [STAT_CNT_WIDTH-1:0] pop_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bypass_cnt_q <= '0;
            insert_cnt_q <= '0;
            pop_cnt_q    <= '0;
        end else begin
            bypass_cnt_q <= sat_inc(bypass_cnt_q, bypass_take);
            insert_cnt_q <= sat_inc(insert_cnt_q, ins_en_q);
            pop_cnt_q    <= sat_inc(pop_cnt_q, pop_q);
        end
    end

    assign stat_bypass_cnt = bypass_cnt_q;
    assign stat_insert_cnt = insert_cnt_q;
    assign stat_pop_cnt    = pop_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pifo_root_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_root_dispatcher
// Purpose  : Self-checking bench for pifo_root_dispatcher (BYPASS_SYNC=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_root_dispatcher;
    import pifo_root_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pifo_root_dispatcher_if bus ();

`ifdef DISPATCH_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] stat_b, stat_i, stat_p;
`endif

    pifo_root_dispatcher dut (
        .clk  (clk),
        .rstn (rstn),
        .disp (bus)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_bypass_cnt (stat_b),
        .stat_insert_cnt (stat_i),
        .stat_pop_cnt    (stat_p)
`endif
    );

    typedef struct {
        logic        ins;
        logic        byp;
        logic [31:0] info;
        logic [31:0] top;
        logic        rdy;
        logic        push;
        logic [11:0] paddr;
        logic [18:0] prank;
        logic        ov;
        logic [11:0] oaddr;
        logic [18:0] orank;
        logic        ie;
        logic [31:0] iinfo;
        logic        pop;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [18:0] rank;
    } xfer_t;

    xfer_t sb[$];
    vec_t  vt[30];

    function automatic logic [31:0] ent(input logic v, input int rank, input int addr);
        logic [18:0] r;
        logic [11:0] a;
        r = rank[18:0];
        a = addr[11:0];
        return {v, r, a};
    endfunction

    function automatic vec_t mkv(
        input logic ins, input logic byp, input logic [31:0] info,
        input logic [31:0] top, input logic rdy,
        input logic push, input int paddr, input int prank,
        input logic ov, input int oaddr, input int orank,
        input logic ie, input logic [31:0] iinfo, input logic pop
    );
        vec_t v;
        v.ins = ins; v.byp = byp; v.info = info; v.top = top; v.rdy = rdy;
        v.push = push; v.paddr = paddr[11:0]; v.prank = prank[18:0];
        v.ov = ov; v.oaddr = oaddr[11:0]; v.orank = orank[18:0];
        v.ie = ie; v.iinfo = iinfo; v.pop = pop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ins, input logic byp, input logic [31:0] info,
                         input logic [31:0] top, input logic rdy);
        bus.s_insert_en    = ins;
        bus.s_bypass_en    = byp;
        bus.s_pifo_info    = info;
        bus.s_calendar_top = top;
        bus.m_out_ready    = rdy;
    endtask

    // Output transfers are matched against the expected queue in order
    always @(negedge clk) begin
        if (rstn && bus.m_out_valid && bus.m_out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got addr %h rank %h expected none",
                         bus.m_out_addr, bus.m_out_rank);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                chk("xfer_addr", 32'(bus.m_out_addr), 32'(e.addr));
                chk("xfer_rank", 32'(bus.m_out_rank), 32'(e.rank));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t x;
        logic [31:0] z;
        z = '0;
        //              ins byp info             top              rdy push paddr prank ov oaddr orank ie iinfo           pop
        vt[0]  = mkv(1, 0, ent(1, 5, 'h005),  z,               1, 1, 'h005, 5,  0, 0, 0,      0, z,               0);
        vt[1]  = mkv(0, 1, z,                 z,               1, 0, 0, 0,      1, 'h005, 5,   0, z,               0);
        vt[2]  = mkv(1, 0, ent(1, 9, 'h009),  z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[3]  = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       1, ent(1, 9, 'h009), 0);
        vt[4]  = mkv(1, 0, ent(1, 7, 'h007),  z,               0, 1, 'h007, 7,  0, 0, 0,       0, z,               0);
        vt[5]  = mkv(1, 1, ent(1, 8, 'h008),  z,               0, 0, 0, 0,      1, 'h007, 7,   0, z,               0);
        vt[6]  = mkv(0, 1, z,                 z,               0, 0, 0, 0,      1, 'h007, 7,   1, ent(1, 8, 'h008), 0);
        vt[7]  = mkv(0, 0, z,                 ent(1, 20, 'h3A), 0, 0, 0, 0,     1, 'h007, 7,   0, z,               0);
        vt[8]  = mkv(0, 0, z,                 ent(1, 20, 'h3A), 1, 1, 'h3A, 20, 1, 'h3A, 20,   0, z,               1);
        vt[9]  = mkv(0, 0, z,                 ent(1, 21, 'h3B), 0, 0, 0, 0,     1, 'h3A, 20,   0, z,               0);
        vt[10] = mkv(0, 0, z,                 ent(1, 21, 'h3B), 0, 0, 0, 0,     1, 'h3A, 20,   0, z,               0);
        vt[11] = mkv(0, 0, z,                 ent(1, 21, 'h3B), 1, 1, 'h3B, 21, 1, 'h3B, 21,   0, z,               1);
        vt[12] = mkv(0, 0, z,                 ent(1, 22, 'h3C), 1, 0, 0, 0,     0, 0, 0,       0, z,               0);
        vt[13] = mkv(0, 0, z,                 ent(1, 22, 'h3C), 1, 1, 'h3C, 22, 1, 'h3C, 22,   0, z,               1);
        vt[14] = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[15] = mkv(1, 0, ent(1, 3, 'h011),  z,               0, 1, 'h011, 3,  0, 0, 0,       0, z,               0);
        vt[16] = mkv(0, 1, z,                 ent(1, 30, 'h5A), 0, 0, 0, 0,     1, 'h011, 3,   0, z,               0);
        vt[17] = mkv(0, 0, z,                 ent(1, 30, 'h5A), 0, 0, 0, 0,     1, 'h011, 3,   0, z,               0);
        vt[18] = mkv(0, 0, z,                 ent(1, 30, 'h5A), 1, 1, 'h5A, 30, 1, 'h5A, 30,   0, z,               1);
        vt[19] = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[20] = mkv(1, 0, ent(0, 4, 'h004),  z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[21] = mkv(1, 1, ent(0, 6, 'h006),  z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[22] = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[23] = mkv(1, 0, ent(1, 40, 'h100), z,               1, 1, 'h100, 40, 0, 0, 0,       0, z,               0);
        vt[24] = mkv(1, 1, ent(1, 41, 'h101), z,               1, 1, 'h101, 41, 1, 'h100, 40,  0, z,               0);
        vt[25] = mkv(0, 1, z,                 z,               1, 0, 0, 0,      1, 'h101, 41,  0, z,               0);
        vt[26] = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[27] = mkv(1, 0, ent(1, 50, 'h200), z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);
        vt[28] = mkv(0, 0, z,                 ent(1, 60, 'h300), 0, 1, 'h300, 60, 1, 'h300, 60, 1, ent(1, 50, 'h200), 1);
        vt[29] = mkv(0, 0, z,                 z,               1, 0, 0, 0,      0, 0, 0,       0, z,               0);

        // Reset state
        drive(0, 0, z, z, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.m_out_valid), 32'd0);
        chk("rst_pop", 32'(bus.m_calendar_pop), 32'd0);
        chk("rst_ins_en", 32'(bus.m_insert_en), 32'd0);
        chk("rst_ins_info", bus.m_insert_info, 32'd0);
        rstn = 1'b1;

        // Table: inputs held one cycle, outputs checked after the edge
        for (int i = 0; i < 30; i++) begin
            drive(vt[i].ins, vt[i].byp, vt[i].info, vt[i].top, vt[i].rdy);
            if (vt[i].push) begin
                x.addr = vt[i].paddr;
                x.rank = vt[i].prank;
                sb.push_back(x);
            end
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(bus.m_out_valid), 32'(vt[i].ov));
            chk($sformatf("row%0d_ins_en", i), 32'(bus.m_insert_en), 32'(vt[i].ie));
            chk($sformatf("row%0d_pop", i), 32'(bus.m_calendar_pop), 32'(vt[i].pop));
            if (vt[i].ov) begin
                chk($sformatf("row%0d_addr", i), 32'(bus.m_out_addr), 32'(vt[i].oaddr));
                chk($sformatf("row%0d_rank", i), 32'(bus.m_out_rank), 32'(vt[i].orank));
            end
            if (vt[i].ie) begin
                chk($sformatf("row%0d_ins_info", i), bus.m_insert_info, vt[i].iinfo);
            end
        end

        // Reset with a staged arrival and a full stalled slot
        drive(1, 0, ent(1, 70, 'h070), z, 0);
        @(posedge clk);
        #1;
        drive(1, 1, ent(1, 71, 'h071), z, 0);
        @(posedge clk);
        #1;
        chk("prerst_valid", 32'(bus.m_out_valid), 32'd1);
        chk("prerst_rank", 32'(bus.m_out_rank), 32'd70);
        rstn = 1'b0;
        drive(0, 1, z, ent(1, 80, 'h080), 0);
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.m_out_valid), 32'd0);
        chk("midrst_pop", 32'(bus.m_calendar_pop), 32'd0);
        chk("midrst_ins_en", 32'(bus.m_insert_en), 32'd0);
        chk("midrst_ins_info", bus.m_insert_info, 32'd0);
        chk("midrst_addr", 32'(bus.m_out_addr), 32'd0);
        chk("midrst_rank", 32'(bus.m_out_rank), 32'd0);
        rstn = 1'b1;
        drive(0, 1, z, z, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d_ins_en", k), 32'(bus.m_insert_en), 32'd0);
            chk($sformatf("postrst%0d_pop", k), 32'(bus.m_calendar_pop), 32'd0);
            chk($sformatf("postrst%0d_valid", k), 32'(bus.m_out_valid), 32'd0);
        end

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
